// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// Decode-to-execute pipeline register. It also contains the hazard logic for
// this boundary: load-use detection, flush handling, and freezing the stage
// while downstream memory is busy.
//
// Ports
//   clk                 single clock; all state changes on the rising edge
//   rst                 synchronous active-low reset
//   valid_d, ctrl_d     decode slot live flag and the 22-bit control bundle
//   pc_d, rs1_data_d,
//   rs2_data_d, imm_d   decode datapath values (XLEN bits each)
//   rs1_d, rs2_d, rd_d  decode register indices
//   flush               execute resolved a taken branch/jump this cycle
//   mem_busy            downstream memory not ready; freeze this stage
//   *_e                 registered copies of the decode fields for execute
//   stall_d             combinational: hold the PC and the IF/ID register
//   flush_d             combinational: the IF/ID register loads a bubble
//   stall_cnt           saturating count of cycles with stall_d asserted
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_d,
  input  logic [21:0]      ctrl_d,
  input  logic [XLEN-1:0]  pc_d,
  input  logic [XLEN-1:0]  rs1_data_d,
  input  logic [XLEN-1:0]  rs2_data_d,
  input  logic [XLEN-1:0]  imm_d,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_d,
  input  logic             flush,
  input  logic             mem_busy,
  output logic             valid_e,
  output logic [21:0]      ctrl_e,
  output logic [XLEN-1:0]  pc_e,
  output logic [XLEN-1:0]  rs1_data_e,
  output logic [XLEN-1:0]  rs2_data_e,
  output logic [XLEN-1:0]  imm_e,
  output logic [4:0]       rs1_e,
  output logic [4:0]       rs2_e,
  output logic [4:0]       rd_e,
  output logic             stall_d,
  output logic             flush_d,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             ex_valid_q,    ex_valid_d;
  logic [21:0]      ex_ctrl_q,     ex_ctrl_d;
  logic [XLEN-1:0]  ex_pc_q,       ex_pc_d;
  logic [XLEN-1:0]  ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0]  ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0]  ex_imm_q,      ex_imm_d;
  logic [4:0]       ex_rs1_q,      ex_rs1_d;
  logic [4:0]       ex_rs2_q,      ex_rs2_d;
  logic [4:0]       ex_rd_q,       ex_rd_d;
  logic             flush_pend_q,  flush_pend_d;
  logic [CNT_W-1:0] stall_cnt_q,   stall_cnt_d;

  logic lu_s;
  logic flush_eff_s;
  logic stall_s;

  // Hazard detection and the two combinational handshake outputs.
  always_comb begin
    // ctrl bit 11 is MemRead: a load is sitting in execute.
    lu_s = ex_valid_q & ex_ctrl_q[11] & (ex_rd_q != 5'd0) & valid_d &
           ((ex_rd_q == rs1_d) | (ex_rd_q == rs2_d));
    // A flush that arrived while frozen is replayed on the first free cycle.
    flush_eff_s = flush | flush_pend_q;
    stall_s     = (lu_s & ~flush_eff_s) | mem_busy;
    stall_d     = stall_s;
    flush_d     = flush_eff_s & ~mem_busy;
  end

  // Next-state selection for the execute register, pending flush and counter.
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_ctrl_d     = ex_ctrl_q;
    ex_pc_d       = ex_pc_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_imm_d      = ex_imm_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_rd_d       = ex_rd_q;
    flush_pend_d  = flush_pend_q;
    stall_cnt_d   = stall_cnt_q;

    if (mem_busy) begin
      // Frozen: keep the execute contents and remember any flush request.
      flush_pend_d = flush_pend_q | flush;
    end else if (flush_eff_s | lu_s) begin
      // Bubble: a killed instruction or the slot a load-use stall opens up.
      // The data fields are zeroed as well, so the bubble is fully clean.
      flush_pend_d  = 1'b0;
      ex_valid_d    = 1'b0;
      ex_ctrl_d     = 22'd0;
      ex_pc_d       = {XLEN{1'b0}};
      ex_rs1_data_d = {XLEN{1'b0}};
      ex_rs2_data_d = {XLEN{1'b0}};
      ex_imm_d      = {XLEN{1'b0}};
      ex_rs1_d      = 5'd0;
      ex_rs2_d      = 5'd0;
      ex_rd_d       = 5'd0;
    end else begin
      flush_pend_d  = 1'b0;
      ex_valid_d    = valid_d;
      ex_ctrl_d     = ctrl_d;
      ex_pc_d       = pc_d;
      ex_rs1_data_d = rs1_data_d;
      ex_rs2_data_d = rs2_data_d;
      ex_imm_d      = imm_d;
      ex_rs1_d      = rs1_d;
      ex_rs2_d      = rs2_d;
      ex_rd_d       = rd_d;
    end

    // Saturating stall counter; it never wraps back to zero.
    if (stall_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= 22'd0;
      ex_pc_q       <= {XLEN{1'b0}};
      ex_rs1_data_q <= {XLEN{1'b0}};
      ex_rs2_data_q <= {XLEN{1'b0}};
      ex_imm_q      <= {XLEN{1'b0}};
      ex_rs1_q      <= 5'd0;
      ex_rs2_q      <= 5'd0;
      ex_rd_q       <= 5'd0;
      flush_pend_q  <= 1'b0;
      stall_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      flush_pend_q  <= flush_pend_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign valid_e    = ex_valid_q;
  assign ctrl_e     = ex_ctrl_q;
  assign pc_e       = ex_pc_q;
  assign rs1_data_e = ex_rs1_data_q;
  assign rs2_data_e = ex_rs2_data_q;
  assign imm_e      = ex_imm_q;
  assign rs1_e      = ex_rs1_q;
  assign rs2_e      = ex_rs2_q;
  assign rd_e       = ex_rd_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, 32, datapath width of PC, operands, immediate.
REQ-002 Parameter CNT_W, 16, width of stall performance counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-low reset; sampled on rising clk edge only.
REQ-005 valid_d  in  1  decode slot holds a live instruction.
REQ-006 ctrl_d  in  22  decode controls: [21:20] ALUSrcA, [19:18] ALUSrcB, [17:16] ShiftAmnt, [15:13] SignExt, [12] MemWrite, [11] MemRead, [10] RegWrite, [9] Jump, [8] Branch, [7] XorZero, [6] MemtoReg, [5] JalrMux, [4:0] ALUControl.
REQ-007 pc_d, rs1_data_d, rs2_data_d, imm_d  in  XLEN each  decode PC, register-file operands, sign-extended immediate.
REQ-008 rs1_d, rs2_d, rd_d  in  5 each  decode register indices.
REQ-009 flush  in  1  EX resolved taken branch/jump; kill younger instruction in decode.
REQ-010 mem_busy  in  1  downstream memory not ready; freeze this stage.
REQ-011 valid_e, ctrl_e, pc_e, rs1_data_e, rs2_data_e, imm_e, rs1_e, rs2_e, rd_e  out  1/22/XLEN x4/5 x3  registered copies for execute.
REQ-012 stall_d  out  1  combinational; hold PC and IF/ID register this cycle.
REQ-013 flush_d  out  1  combinational; IF/ID register to load a bubble.
REQ-014 stall_cnt  out  CNT_W  count of cycles with stall_d or mem_busy asserted.

Function
REQ-015 Load-use hazard lu = valid_e & ctrl_e[11] & (rd_e != 0) & valid_d & ((rd_e == rs1_d) | (rd_e == rs2_d)).
REQ-016 stall_d SHALL equal lu & ~flush_eff | mem_busy, where flush_eff = flush | flush_pend.
REQ-017 flush_d SHALL equal flush_eff & ~mem_busy.
REQ-018 Per-edge priority: reset > mem_busy hold > flush_eff bubble > lu bubble > load.
REQ-019 Hold: all E outputs retain value while mem_busy = 1.
REQ-020 Bubble: valid_e = 0, ctrl_e = 0, rd_e = 0; other E data fields don't-care but SHALL be zeroed.
REQ-021 Load: every E output takes its _d input next edge (latency 1 cycle).
REQ-022 flush asserted while mem_busy = 1 SHALL set flush_pend; flush_pend applies as flush_eff on first cycle mem_busy = 0, then clears that edge.
REQ-023 flush_pend SHALL clear on any edge where flush_eff is consumed (mem_busy = 0), including when flush is also high.
REQ-024 Bubbled instruction (lu) SHALL re-present next cycle with valid_e = 0, so lu deasserts automatically; max consecutive lu stalls = 1.
REQ-025 rd = 0 load never creates a hazard; valid_d = 0 never creates a hazard.
REQ-026 stall_cnt increments by 1 each edge where stall_d = 1; saturates at all-ones, never wraps.
REQ-027 No combinational path from any _d data input to any E output.

Reset
REQ-028 With rst = 0 at an edge: valid_e = 0, ctrl_e = 0, all data/index outputs = 0, flush_pend = 0, stall_cnt = 0, regardless of mem_busy/flush.
REQ-029 Reset mid-stall or with flush_pend set SHALL discard pending state; first post-reset cycle behaves as empty pipeline.

Verification
REQ-030 Load x5 (ctrl_d[11]=1, rd_d=5) then add rs1_d=5 -> one cycle stall_d=1, valid_e=0 bubble, add enters E next cycle; stall_cnt=1.
REQ-031 Load rd_d=0 followed by rs1_d=0 consumer -> stall_d=0, no bubble.
REQ-032 mem_busy=1 for 3 cycles with flush pulsed in cycle 2 -> E outputs frozen, flush_d=0, stall_cnt=3; cycle after busy drops flush_d=1 and valid_e=0.
REQ-033 flush and lu same cycle -> flush_d=1, stall_d=0, valid_e=0 next edge.
REQ-034 Force stall_cnt near all-ones via 2^CNT_W stall cycles -> holds at 0xFFFF (CNT_W=16).
REQ-035 rst=0 during mem_busy=1 with pending flush -> all outputs 0 next edge, flush_d=0 after rst returns 1.
